// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: op codes, access sizes, FSM states and an
// alignment helper.
package lsu_pkg;

    localparam logic [2:0] L_OP = 3'b010;
    localparam logic [2:0] S_OP = 3'b011;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    // Low-address mask covering the bytes inside one naturally aligned access.
    function automatic logic [2:0] size_mask(size_e sz);
        return 3'((4'd1 << sz) - 4'd1);
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Execute-side handshake plus data-memory port of the load/store controller.
interface lsu_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              valid_i;
    logic              ready_o;
    logic [2:0]        op_i;
    logic [1:0]        size_i;
    logic              unsigned_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;

    logic                mem_req_o;
    logic                mem_gnt_i;
    logic                mem_we_o;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic [DATA_W/8-1:0] mem_be_o;
    logic [DATA_W-1:0]   mem_wdata_o;
    logic                mem_rvalid_i;
    logic [DATA_W-1:0]   mem_rdata_i;
    logic                mem_read_o;
    logic                mem_write_o;

    logic              done_o;
    logic [DATA_W-1:0] rdata_o;
    logic              err_o;

    modport slave (
        input  valid_i, op_i, size_i, unsigned_i, addr_i, wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_read_o, mem_write_o, done_o, rdata_o, err_o
    );

    modport master (
        output valid_i, op_i, size_i, unsigned_i, addr_i, wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_read_o, mem_write_o, done_o, rdata_o, err_o
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load extraction and
// sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned NB    = DATA_W / 8,
    localparam int unsigned OFF_W = $clog2(NB)
) (
    input  size_e             size_i,
    input  logic              unsigned_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [NB-1:0]     be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [NB-1:0]     be_base;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        be_base = '0;
        wdata_o = wdata_i;
        rdata_o = '0;
        shifted = rdata_i >> {offset_i, 3'b000};
        unique case (size_i)
            SZ_B: begin
                be_base = NB'(1);
                for (int i = 0; i < NB; i++) wdata_o[i*8 +: 8] = wdata_i[7:0];
                rdata_o = unsigned_i ? DATA_W'(shifted[7:0]) : DATA_W'($signed(shifted[7:0]));
            end
            SZ_H: begin
                be_base = NB'(3);
                for (int i = 0; i < NB / 2; i++) wdata_o[i*16 +: 16] = wdata_i[15:0];
                rdata_o = unsigned_i ? DATA_W'(shifted[15:0])
                                     : DATA_W'($signed(shifted[15:0]));
            end
            SZ_W: begin
                be_base = NB'(4'hF);
                for (int i = 0; i < NB / 4; i++) wdata_o[i*32 +: 32] = wdata_i[31:0];
                rdata_o = unsigned_i ? DATA_W'(shifted[31:0])
                                     : DATA_W'($signed(shifted[31:0]));
            end
            default: begin
                be_base = NB'(8'hFF);
                rdata_o = shifted;
            end
        endcase
        be_o = be_base << offset_i;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store controller: one operation at a time over a req/gnt/rvalid port.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned accesses into immediate error completions.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic       clk_i,
    input logic       rst_i,
    lsu_ctrl_if.slave bus
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e            state_q, state_d;
    logic              is_load_q;
    size_e             size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept, cnt_clr, capture, tmo, trap, timeout;
    size_e             in_size;
    logic [ADDR_W-1:0] aligned_addr;
    logic [NB-1:0]     al_be;
    logic [DATA_W-1:0] al_wdata, al_rdata;

    assign in_size      = size_e'(bus.size_i);
    assign aligned_addr = bus.addr_i & ~ADDR_W'(size_mask(in_size));
    assign accept       = (state_q == IDLE) && bus.valid_i &&
                          (bus.op_i == L_OP || bus.op_i == S_OP);
    assign timeout      = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef LSU_MISALIGN_TRAP_EN
    logic [2:0] in_off;
    logic       misaligned;
    assign in_off     = 3'(bus.addr_i[OFF_W-1:0]);
    assign misaligned = |(in_off & size_mask(in_size));
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        capture = 1'b0;
        tmo     = 1'b0;
        trap    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_d = DONE;
                        trap    = 1'b1;
                    end else begin
                        state_d = REQ;
                        cnt_clr = 1'b1;
                    end
`else
                    state_d = REQ;
                    cnt_clr = 1'b1;
`endif
                end
            end
            REQ: begin
                if (bus.mem_gnt_i) begin
                    state_d = is_load_q ? WAIT : DONE;
                    cnt_clr = 1'b1;
                end else if (timeout) begin
                    state_d = DONE;
                    tmo     = 1'b1;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid_i) begin
                    state_d = DONE;
                    capture = 1'b1;
                end else if (timeout) begin
                    state_d = DONE;
                    tmo     = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            is_load_q <= 1'b0;
            size_q    <= SZ_B;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (accept) begin
                is_load_q <= (bus.op_i == L_OP);
                size_q    <= in_size;
                uns_q     <= bus.unsigned_i;
                addr_q    <= aligned_addr;
                wdata_q   <= bus.wdata_i;
                rdata_q   <= '0;
                err_q     <= trap;
            end
            if (capture) rdata_q <= al_rdata;
            if (tmo)     err_q   <= 1'b1;
            if (cnt_clr)                                cnt_q <= '0;
            else if (state_q == REQ || state_q == WAIT) cnt_q <= cnt_q + 1'b1;
        end
    end

    lsu_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .size_i    (size_q),
        .unsigned_i(uns_q),
        .offset_i  (addr_q[OFF_W-1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (bus.mem_rdata_i),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .rdata_o   (al_rdata)
    );

    // Bus fields are gated to zero outside REQ so idle/reset outputs read as zero.
    assign bus.ready_o     = (state_q == IDLE);
    assign bus.mem_req_o   = (state_q == REQ);
    assign bus.mem_we_o    = (state_q == REQ) && !is_load_q;
    assign bus.mem_addr_o  = (state_q == REQ) ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign bus.mem_be_o    = (state_q == REQ) ? al_be : '0;
    assign bus.mem_wdata_o = (state_q == REQ && !is_load_q) ? al_wdata : '0;
    assign bus.mem_read_o  = (state_q == REQ || state_q == WAIT) && is_load_q;
    assign bus.mem_write_o = (state_q == REQ || state_q == WAIT) && !is_load_q;
    assign bus.done_o      = (state_q == DONE);
    assign bus.rdata_o     = (state_q == DONE) ? rdata_q : '0;
    assign bus.err_o       = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a transaction-level model predicts per-cycle outputs.
module tb_lsu_ctrl;

    localparam int TO = 16;

    typedef struct {
        int          acc, req_hi, busy_hi, end_c, done_c;
        logic        load, trap, err;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  be;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t ex;

    lsu_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu_ctrl #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
        end
    endtask

    function automatic exp_t model(input int a, input logic [2:0] op, input logic [1:0] sz,
                                   input logic uns, input logic [31:0] addr, wdata, rdata,
                                   input int gd, rd);
        exp_t        e;
        int          bytes, off;
        logic [31:0] mask, v;
        bytes  = 1 << sz;
        off    = (int'(addr[1:0]) / bytes) * bytes;
        e.acc  = a;
        e.load = (op == 3'b010);
        e.trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        e.trap = (int'(addr[1:0]) % bytes) != 0;
`endif
        e.addr = addr & ~32'd3;
        e.be   = 4'(((1 << bytes) - 1) << off);
        for (int i = 0; i < 4; i++) e.wdata[i*8 +: 8] = wdata[(i % bytes)*8 +: 8];
        mask = (bytes == 4) ? 32'hFFFF_FFFF : (32'd1 << (bytes * 8)) - 32'd1;
        v    = (rdata >> (off * 8)) & mask;
        if (!uns && v[bytes*8-1]) v = v | ~mask;
        e.err   = 1'b0;
        e.rdata = 32'd0;
        if (e.trap) begin
            e.req_hi = a;
            e.done_c = a + 1;
            e.err    = 1'b1;
        end else if (gd < 0 || gd >= TO) begin
            e.req_hi = a + TO;
            e.done_c = a + 1 + TO;
            e.err    = 1'b1;
        end else begin
            e.req_hi = a + 1 + gd;
            if (!e.load) begin
                e.done_c = a + 2 + gd;
            end else if (rd >= 0 && rd < TO) begin
                e.done_c = a + 3 + gd + rd;
                e.rdata  = v;
            end else begin
                e.done_c = a + 2 + gd + TO;
                e.err    = 1'b1;
            end
        end
        e.busy_hi = e.done_c - 1;
        e.end_c   = e.done_c;
        return e;
    endfunction

    always @(negedge clk) begin
        if (cyc >= 1) begin
            logic busy, req, rdy, dn;
            busy = (cyc > ex.acc) && (cyc <= ex.busy_hi);
            req  = (cyc > ex.acc) && (cyc <= ex.req_hi);
            rdy  = !((cyc > ex.acc) && (cyc <= ex.end_c));
            dn   = (cyc == ex.done_c);
            chk("ready", 32'(bus.ready_o), 32'(rdy));
            chk("done", 32'(bus.done_o), 32'(dn));
            chk("mem_req", 32'(bus.mem_req_o), 32'(req));
            chk("mem_read", 32'(bus.mem_read_o), 32'(busy && ex.load));
            chk("mem_write", 32'(bus.mem_write_o), 32'(busy && !ex.load));
            if (req) begin
                chk("mem_addr", bus.mem_addr_o, ex.addr);
                chk("mem_be", 32'(bus.mem_be_o), 32'(ex.be));
                chk("mem_we", 32'(bus.mem_we_o), 32'(!ex.load));
                if (!ex.load) chk("mem_wdata", bus.mem_wdata_o, ex.wdata);
            end
            if (dn) begin
                chk("rdata", bus.rdata_o, ex.rdata);
                chk("err", 32'(bus.err_o), 32'(ex.err));
            end
            if (rst_q) begin
                chk("rst_addr", bus.mem_addr_o, 32'd0);
                chk("rst_be", 32'(bus.mem_be_o), 32'd0);
                chk("rst_wdata", bus.mem_wdata_o, 32'd0);
                chk("rst_we", 32'(bus.mem_we_o), 32'd0);
                chk("rst_rdata", bus.rdata_o, 32'd0);
                chk("rst_err", 32'(bus.err_o), 32'd0);
            end
        end
    end

    task automatic run(input logic [2:0] op, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, wdata, rdata, input int gd, rd,
                       input logic [3:0] h_be, input logic [31:0] h_addr, h_wdata, h_rdata,
                       input logic h_err, input int h_lat, input bit rst_mid);
        exp_t e;
        @(posedge clk);
        #1;
        bus.valid_i     = 1'b1;
        bus.op_i        = op;
        bus.size_i      = sz;
        bus.unsigned_i  = uns;
        bus.addr_i      = addr;
        bus.wdata_i     = wdata;
        bus.mem_rdata_i = rdata;
        if (op != 3'b010 && op != 3'b011) begin
            // Dropped op, with stray gnt/rvalid that IDLE must ignore.
            bus.mem_gnt_i    = 1'b1;
            bus.mem_rvalid_i = 1'b1;
            @(posedge clk);
            #1;
            bus.valid_i      = 1'b0;
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b0;
            return;
        end
        e = model(cyc, op, sz, uns, addr, wdata, rdata, gd, rd);
        chk("pin_err", 32'(e.err), 32'(h_err));
        chk("pin_lat", 32'(e.done_c - e.acc), 32'(h_lat));
        chk("pin_rdata", e.rdata, h_rdata);
        if (!e.trap) begin
            chk("pin_be", 32'(e.be), 32'(h_be));
            chk("pin_addr", e.addr, h_addr);
            if (!e.load) chk("pin_wdata", e.wdata, h_wdata);
        end
        ex = e;
        do begin
            @(posedge clk);
            #1;
            bus.valid_i      = 1'b0;
            bus.mem_gnt_i    = (gd >= 0) && (cyc == e.acc + 1 + gd);
            bus.mem_rvalid_i = e.load && (gd >= 0) && (rd >= 0) && (cyc == e.acc + 2 + gd + rd);
            if (rst_mid && cyc == e.acc + 2) begin
                rst        = 1'b1;
                ex.busy_hi = cyc;
                ex.end_c   = cyc;
                ex.done_c  = -1;
            end
            if (rst_mid && cyc == e.acc + 3) begin
                rst              = 1'b0;
                bus.mem_rvalid_i = 1'b1;
            end
        end while (cyc < (rst_mid ? e.acc + 4 : e.done_c));
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end

    initial begin
        ex.acc = -100; ex.req_hi = -100; ex.busy_hi = -100; ex.end_c = -100; ex.done_c = -100;
        ex.load = 1'b0; ex.trap = 1'b0; ex.err = 1'b0;
        ex.addr = '0; ex.wdata = '0; ex.rdata = '0; ex.be = '0;
        bus.valid_i = 1'b0; bus.op_i = 3'b000; bus.size_i = 2'b00; bus.unsigned_i = 1'b0;
        bus.addr_i = '0; bus.wdata_i = '0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        //  op      sz     uns   addr          wdata         rdata         gd  rd
        //  be     addr          wdata         rdata         err  lat rst
        run(3'b011, 2'b10, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,        0,  0,
            4'hF, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,        1'b0, 2, 1'b0);
        run(3'b010, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'h8000_0000, 0,  0,
            4'h8, 32'h0000_1000, 32'h0,        32'hFFFF_FF80, 1'b0, 3, 1'b0);
        run(3'b010, 2'b00, 1'b1, 32'h0000_1003, 32'h0,        32'h8000_0000, 0,  0,
            4'h8, 32'h0000_1000, 32'h0,        32'h0000_0080, 1'b0, 3, 1'b0);
        run(3'b011, 2'b01, 1'b0, 32'h0000_1002, 32'hABCD_1234, 32'h0,        0,  0,
            4'hC, 32'h0000_1000, 32'h1234_1234, 32'h0,        1'b0, 2, 1'b0);
        run(3'b010, 2'b10, 1'b0, 32'h0000_2000, 32'h0,        32'h1111_1111, -1, 0,
            4'hF, 32'h0000_2000, 32'h0,        32'h0,        1'b1, 17, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        run(3'b010, 2'b01, 1'b0, 32'h0000_1001, 32'h0,        32'h7FFF_8001, 0,  0,
            4'h3, 32'h0000_1000, 32'h0,        32'h0,        1'b1, 1, 1'b0);
`else
        run(3'b010, 2'b01, 1'b0, 32'h0000_1001, 32'h0,        32'h7FFF_8001, 0,  0,
            4'h3, 32'h0000_1000, 32'h0,        32'hFFFF_8001, 1'b0, 3, 1'b0);
`endif
        run(3'b011, 2'b00, 1'b0, 32'h0000_1001, 32'h0000_005A, 32'h0,        3,  0,
            4'h2, 32'h0000_1000, 32'h5A5A_5A5A, 32'h0,        1'b0, 5, 1'b0);
        run(3'b010, 2'b01, 1'b1, 32'h0000_1006, 32'h0,        32'hBEEF_1234, 1,  2,
            4'hC, 32'h0000_1004, 32'h0,        32'h0000_BEEF, 1'b0, 6, 1'b0);
        run(3'b010, 2'b10, 1'b0, 32'h0000_2004, 32'h0,        32'h8765_4321, 2,  -1,
            4'hF, 32'h0000_2004, 32'h0,        32'h0,        1'b1, 20, 1'b0);
        run(3'b001, 2'b10, 1'b0, 32'h0000_3000, 32'h0,        32'h0,        0,  0,
            4'h0, 32'h0,        32'h0,        32'h0,        1'b0, 0, 1'b0);
        run(3'b010, 2'b00, 1'b0, 32'h0000_1002, 32'h0,        32'h007F_0000, 0,  0,
            4'h4, 32'h0000_1000, 32'h0,        32'h0000_007F, 1'b0, 3, 1'b0);
        run(3'b010, 2'b10, 1'b0, 32'h0000_1000, 32'h0,        32'hCAFE_F00D, 0,  -1,
            4'hF, 32'h0000_1000, 32'h0,        32'h0,        1'b1, 18, 1'b1);
        run(3'b011, 2'b10, 1'b0, 32'h0000_3000, 32'h0BAD_F00D, 32'h0,        5,  0,
            4'hF, 32'h0000_3000, 32'h0BAD_F00D, 32'h0,        1'b0, 7, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
